// File: rtl/flasher_pkg.sv
// Shared definitions for the bound flasher and its flick controller:
// flasher status encoding, sweep geometry and the controller state set.
package flasher_pkg;

    // Flasher status encoding as reported on fl_state
    localparam logic [1:0] FL_STOP = 2'b00;
    localparam logic [1:0] FL_IDLE = 2'b01;
    localparam logic [1:0] FL_UP   = 2'b10;
    localparam logic [1:0] FL_DOWN = 2'b11;

    // Sweep geometry of the flasher
    localparam logic [3:0] MAX_STEP = 4'd5;
    localparam logic [3:0] POS_LED0 = 4'd0;
    localparam logic [3:0] POS_LED5 = 4'd5;

    // Controller states
    typedef enum logic [1:0] {
        C_INIT = 2'd0,
        C_WAIT = 2'd1,
        C_FIRE = 2'd2,
        C_HOLD = 2'd3
    } ctrl_state_e;

    // A flick is only meaningful while idle, or on a down sweep resting at an
    // end LED position that is not the last step.
    function automatic logic flick_window(input logic [1:0] st,
                                          input logic [3:0] idx,
                                          input logic [3:0] led);
        return (st == FL_IDLE) ||
               ((st == FL_DOWN) && (idx != MAX_STEP) &&
                ((led == POS_LED0) || (led == POS_LED5)));
    endfunction

endpackage

// File: rtl/flick_debounce.sv
// One push-button input path: 2-flop synchronizer, consecutive-cycle
// debouncer and rising-edge detect on the debounced level.
module flick_debounce #(
    parameter int DEBOUNCE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous button level into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Flip the level once the synced value has disagreed for DEBOUNCE cycles in a row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DEBOUNCE - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_rise = r_level & ~r_level_d;

endmodule

// File: rtl/flasher_flick_ctrl.sv
// Flick sequencer/arbiter in front of the bound flasher. Debounced requests
// latch into pending, a round-robin arbiter picks one, and the FSM issues a
// single registered flick pulse inside a flasher accept window.
//
// Handshake: flick/grant are a one-cycle pulse (no ready). The flasher
// acknowledges by reporting fl_state==UP while the controller is in C_HOLD;
// if that does not happen within HOLD_TO cycles the request stays pending
// and is re-arbitrated from the same pointer.
module flasher_flick_ctrl
    import flasher_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DEBOUNCE = 8,
    parameter int HOLD_TO  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [1:0]              fl_state,
    input  logic [3:0]              fl_index,
    input  logic [3:0]              fl_led_val,
    output logic                    flick,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [NREQ-1:0]         pending,
    output logic                    busy,
    output logic [7:0]              run_count,
    output ctrl_state_e             dbg_state
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(HOLD_TO + 1);

    ctrl_state_e     r_state;
    ctrl_state_e     w_state_nxt;
    logic            r_flick;
    logic [NREQ-1:0] r_grant;
    logic [IW-1:0]   r_grant_id;
    logic [NREQ-1:0] r_pending;
    logic [IW-1:0]   r_ptr;
    logic [HW-1:0]   r_hold;
    logic            r_busy;
    logic [7:0]      r_run;
    logic [1:0]      r_prev_fl;

    logic [NREQ-1:0] w_rise;
    logic [NREQ-1:0] w_clr;
    logic            w_window;
    logic            w_any;
    logic [IW-1:0]   w_win;
    logic            w_fire;
    logic            w_accept;

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        flick_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .i_raw (req[g]),
            .o_rise(w_rise[g])
        );
    end

    assign w_window = flick_window(fl_state, fl_index, fl_led_val);
    assign w_any    = |r_pending;

    // Round-robin pick: first pending bit at or above the pointer, wrapping
    always_comb begin
        int idx;
        idx   = 0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (r_pending[IW'(idx)]) w_win = IW'(idx);
        end
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= C_INIT;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic plus fire/accept strobes
    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            C_INIT: begin
                if (fl_state != FL_STOP) w_state_nxt = C_WAIT;
            end
            C_WAIT: begin
                if (fl_state == FL_STOP) begin
                    w_state_nxt = C_INIT;
                end else if (w_window && w_any) begin
                    w_fire      = 1'b1;
                    w_state_nxt = C_FIRE;
                end
            end
            C_FIRE: begin
                w_state_nxt = C_HOLD;
            end
            C_HOLD: begin
                if (fl_state == FL_STOP) begin
                    w_state_nxt = C_INIT;
                end else if (fl_state == FL_UP) begin
                    w_accept    = 1'b1;
                    w_state_nxt = C_WAIT;
                end else if (r_hold == HW'(1)) begin
                    w_state_nxt = C_WAIT;
                end
            end
            default: w_state_nxt = C_INIT;
        endcase
    end

    // Acceptance clears only the requester that was last granted
    always_comb begin
        w_clr = '0;
        if (w_accept) w_clr[r_grant_id] = 1'b1;
    end

    // Registered pulse outputs; grant_id holds between grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flick    <= 1'b0;
            r_grant    <= '0;
            r_grant_id <= '0;
        end else begin
            r_flick <= w_fire;
            r_grant <= w_fire ? (NREQ'(1) << w_win) : '0;
            if (w_fire) r_grant_id <= w_win;
        end
    end

    // Pending latch (new edge wins over clear) and pointer advance on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_ptr     <= '0;
        end else begin
            r_pending <= w_rise | (r_pending & ~w_clr);
            if (w_accept) begin
                r_ptr <= (r_grant_id == IW'(NREQ - 1)) ? '0 : r_grant_id + IW'(1);
            end
        end
    end

    // Acceptance timeout, loaded on leaving C_FIRE and counted down in C_HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (r_state == C_FIRE) begin
            r_hold <= HW'(HOLD_TO);
        end else if ((r_state == C_HOLD) && (r_hold != '0)) begin
            r_hold <= r_hold - HW'(1);
        end
    end

    // Registered busy so it is 0 out of reset; sweep completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_run     <= '0;
            r_prev_fl <= FL_STOP;
        end else begin
            r_busy    <= (w_state_nxt != C_WAIT) ||
                         (fl_state == FL_UP) || (fl_state == FL_DOWN);
            r_prev_fl <= fl_state;
            if (((r_prev_fl == FL_UP) || (r_prev_fl == FL_DOWN)) && (fl_state == FL_IDLE)) begin
                r_run <= r_run + 8'd1;
            end
        end
    end

    assign flick     = r_flick;
    assign grant     = r_grant;
    assign grant_id  = r_grant_id;
    assign pending   = r_pending;
    assign busy      = r_busy;
    assign run_count = r_run;
    assign dbg_state = r_state;

endmodule
